mul: RTL and testbench

Pipelined IEEE-754 binary32 floating-point multiplier for the network's arithmetic datapath. It computes `out = a * b` with round-to-nearest-even and a fixed two-cycle latency. It accepts a new operand pair every clock and is used wherever neuron weights and activations are multiplied.

---
 rtl/fp32_pkg.sv | 50 +++++
 rtl/fp32_norm_round.sv | 52 +++++
 rtl/mul.sv | 83 ++++++++
 tb/tb_mul.sv | 113 +++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 definitions for the floating-point multiplier:
// field widths, constants, operand layout and operand classes.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int PROD_W = 2 * MANT_W;
    localparam int EXPS_W = 10;
    localparam int BIAS   = 127;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP32_INF  = 32'h7F800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // ZERO must encode as 0 so a cleared pipeline yields +0
    typedef enum logic [1:0] {
        FP_ZERO   = 2'd0,
        FP_NORMAL = 2'd1,
        FP_INF    = 2'd2,
        FP_NAN    = 2'd3
    } fp_class_e;

    typedef struct packed {
        fp_class_e          cls_a;
        fp_class_e          cls_b;
        logic               sign;
        logic [EXPS_W-1:0]  exp_sum;
        logic [PROD_W-1:0]  prod;
    } mul_s1_t;

    function automatic fp_class_e fp32_classify(input fp32_t x);
        fp_class_e c;
        if (x.exp == '0)
            c = FP_ZERO;
        else if (x.exp != '1)
            c = FP_NORMAL;
        else if (x.frac == '0)
            c = FP_INF;
        else
            c = FP_NAN;
        return c;
    endfunction

endpackage

// File: rtl/fp32_norm_round.sv
// Normalizes a 48-bit mantissa product and rounds it to 24 bits,
// nearest-even, reporting exponent overflow and underflow.
module fp32_norm_round
    import fp32_pkg::*;
(
    input  logic [PROD_W-1:0]        prod_i,
    input  logic signed [EXPS_W-1:0] exp_i,
    output logic [FRAC_W-1:0]        frac_o,
    output logic [EXP_W-1:0]         exp_o,
    output logic                     ovf_o,
    output logic                     unf_o
);

    logic [MANT_W-1:0]        mant;
    logic                     guard;
    logic                     sticky;
    logic                     rnd_up;
    logic [MANT_W:0]          sum;
    logic signed [EXPS_W-1:0] exp_n;
    logic signed [EXPS_W-1:0] exp_r;

    always_comb begin
        if (prod_i[PROD_W-1]) begin
            mant   = prod_i[PROD_W-1 -: MANT_W];
            guard  = prod_i[MANT_W-1];
            sticky = |prod_i[MANT_W-2:0];
            exp_n  = exp_i + 10'sd1;
        end else begin
            mant   = prod_i[PROD_W-2 -: MANT_W];
            guard  = prod_i[MANT_W-2];
            sticky = |prod_i[MANT_W-3:0];
            exp_n  = exp_i;
        end

        rnd_up = guard & (sticky | mant[0]);
        sum    = {1'b0, mant} + {{MANT_W{1'b0}}, rnd_up};

        // carry-out means the mantissa rolled over to exactly 2.0
        if (sum[MANT_W]) begin
            frac_o = sum[MANT_W-1:1];
            exp_r  = exp_n + 10'sd1;
        end else begin
            frac_o = sum[FRAC_W-1:0];
            exp_r  = exp_n;
        end

        ovf_o = exp_r >= 10'sd255;
        unf_o = exp_r <= 10'sd0;
        exp_o = exp_r[EXP_W-1:0];
    end

endmodule

// File: rtl/mul.sv
// Two-stage pipelined binary32 multiplier, round-to-nearest-even,
// subnormals flushed to zero, one result per clock.
module mul
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out
);

    fp32_t             fa;
    fp32_t             fb;
    logic [PROD_W-1:0] mant_a;
    logic [PROD_W-1:0] mant_b;
    mul_s1_t           s1_d;
    mul_s1_t           s1_q;
    logic [31:0]       out_d;
    logic [31:0]       out_q;

    always_comb begin
        fa           = fp32_t'(a);
        fb           = fp32_t'(b);
        mant_a       = {{MANT_W{1'b0}}, 1'b1, fa.frac};
        mant_b       = {{MANT_W{1'b0}}, 1'b1, fb.frac};
        s1_d.cls_a   = fp32_classify(fa);
        s1_d.cls_b   = fp32_classify(fb);
        s1_d.sign    = fa.sign ^ fb.sign;
        s1_d.exp_sum = {2'b00, fa.exp} + {2'b00, fb.exp}
                     - 10'(BIAS);
        s1_d.prod    = mant_a * mant_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s1_q <= '0;
        else
            s1_q <= s1_d;
    end

    logic [FRAC_W-1:0] nr_frac;
    logic [EXP_W-1:0]  nr_exp;
    logic              nr_ovf;
    logic              nr_unf;

    fp32_norm_round u_norm_round (
        .prod_i (s1_q.prod),
        .exp_i  ($signed(s1_q.exp_sum)),
        .frac_o (nr_frac),
        .exp_o  (nr_exp),
        .ovf_o  (nr_ovf),
        .unf_o  (nr_unf)
    );

    logic nan_in;
    logic inf_in;
    logic zero_in;

    always_comb begin
        nan_in  = (s1_q.cls_a == FP_NAN)  || (s1_q.cls_b == FP_NAN);
        inf_in  = (s1_q.cls_a == FP_INF)  || (s1_q.cls_b == FP_INF);
        zero_in = (s1_q.cls_a == FP_ZERO) || (s1_q.cls_b == FP_ZERO);
        out_d   = {s1_q.sign, nr_exp, nr_frac};
        // specials take priority in this order
        if (nan_in || (inf_in && zero_in))
            out_d = FP32_QNAN;
        else if (inf_in || nr_ovf)
            out_d = {s1_q.sign, FP32_INF[30:0]};
        else if (zero_in || nr_unf)
            out_d = {s1_q.sign, 31'd0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_q <= '0;
        else
            out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: tb/tb_mul.sv
// Directed-vector bench for the pipelined binary32 multiplier.
// Expected products are hand-computed constants.
module tb_mul;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;

    mul dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic run_vec(input string tag,
                           input logic [31:0] va,
                           input logic [31:0] vb,
                           input logic [31:0] exp);
        @(negedge clk);
        a = va;
        b = vb;
        repeat (2) @(posedge clk);
        #1 check(tag, out, exp);
    endtask

    localparam int N = 8;
    logic [31:0] sa [N] = '{32'h40000000, 32'h3FC00000, 32'hC0000000,
                            32'h3F800001, 32'h3F800003, 32'hFF800001,
                            32'h80000001, 32'h7F800000};
    logic [31:0] sb [N] = '{32'h40400000, 32'h3FC00000, 32'h3F000000,
                            32'h3FC00000, 32'h3FC00000, 32'h3F800000,
                            32'h3F800000, 32'h7F800000};
    logic [31:0] se [N] = '{32'h40C00000, 32'h40100000, 32'hBF800000,
                            32'h3FC00002, 32'h3FC00004, 32'h7FC00000,
                            32'h80000000, 32'h7F800000};

    initial begin
        #2 check("reset_out", out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("p1_51x2_83", 32'h3FC147AE, 32'h40351EB8, 32'h4088BEDF);
        @(negedge clk);
        b = 32'h4069999A;
        @(posedge clk);
        #1 check("hold_prev", out, 32'h4088BEDF);
        @(posedge clk);
        #1 check("p1_51x3_65", out, 32'h40B05E35);
        @(posedge clk);
        #1 check("hold_const", out, 32'h40B05E35);

        run_vec("zero_zero", 32'h00000000, 32'h00000000, 32'h00000000);
        run_vec("negz_one",  32'h80000000, 32'h3F800000, 32'h80000000);
        run_vec("inf_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000);
        run_vec("inf_neg1",  32'h7F800000, 32'hBF800000, 32'hFF800000);
        run_vec("overflow",  32'h7F000000, 32'h40000000, 32'h7F800000);
        run_vec("underflow", 32'h00800000, 32'h00800000, 32'h00000000);
        run_vec("rnd_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002);
        run_vec("rnd_norm",  32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);

        for (int i = 0; i <= N; i++) begin
            @(negedge clk);
            if (i < N) begin
                a = sa[i];
                b = sb[i];
            end
            @(posedge clk);
            #1;
            if (i >= 1)
                check($sformatf("stream%0d", i - 1), out, se[i - 1]);
        end

        // reset mid-stream, between edges
        @(negedge clk);
        a = 32'h40000000;
        b = 32'h40400000;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_async", out, 32'h0);
        @(negedge clk);
        a = 32'h3FC00000;
        b = 32'h3FC00000;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_edge1", out, 32'h0);
        @(posedge clk);
        #1 check("rst_edge2", out, 32'h40100000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
